// File: rtl/flow_rd_scheduler.sv
// flow_rd_scheduler
//   Packet-granular round-robin scheduler for the read side of the segmented
//   buffer. Counts committed packets per flow, grants one flow at a time to
//   the read engine and holds the grant until that packet's last beat leaves.
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   wr_pkt_done/flow    write path committed a full packet on a flow
//   flow_enable         per-flow grant mask (counting continues when masked)
//   rd_req_valid/flow   request to the read engine, held until rd_req_ready
//   rd_req_ready        read engine accepts the request
//   rd_pkt_done         read engine delivered the packet's last beat
//   pkt_pending         per-flow "counter non-zero"
//   busy                a grant is outstanding (REQ or ACTIVE)
//   cnt_overflow        sticky: increment hit a saturated counter
//   proto_err           sticky: rd_pkt_done arrived outside ACTIVE
module flow_rd_scheduler #(
  parameter int FLOWS_W   = 3,
  parameter int PKT_CNT_W = 6
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr_pkt_done,
  input  logic [FLOWS_W-1:0]      wr_pkt_flow,
  input  logic [(2**FLOWS_W)-1:0] flow_enable,
  output logic                    rd_req_valid,
  output logic [FLOWS_W-1:0]      rd_req_flow,
  input  logic                    rd_req_ready,
  input  logic                    rd_pkt_done,
  output logic [(2**FLOWS_W)-1:0] pkt_pending,
  output logic                    busy,
  output logic                    cnt_overflow,
  output logic                    proto_err
);

  localparam int N = 2**FLOWS_W;
  localparam logic [PKT_CNT_W-1:0] CNT_ZERO = {PKT_CNT_W{1'b0}};
  localparam logic [PKT_CNT_W-1:0] CNT_MAX  = {PKT_CNT_W{1'b1}};
  localparam logic [PKT_CNT_W-1:0] CNT_ONE  = {{(PKT_CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t               state_r;
  logic [PKT_CNT_W-1:0] cnt_r [N];
  logic [FLOWS_W-1:0]   rr_ptr_r;
  logic                 rd_req_valid_r;
  logic [FLOWS_W-1:0]   rd_req_flow_r;
  logic                 busy_r;
  logic                 cnt_overflow_r;
  logic                 proto_err_r;

  logic                 hs_s;
  logic [N-1:0]         pending_s;
  logic [N-1:0]         eligible_s;
  logic [N-1:0]         inc_s;
  logic [N-1:0]         dec_s;
  logic [N-1:0]         ovf_s;
  logic [FLOWS_W-1:0]   idx_s;
  logic [FLOWS_W-1:0]   win_s;
  logic                 win_found_s;

  assign hs_s         = rd_req_valid_r & rd_req_ready;
  assign rd_req_valid = rd_req_valid_r;
  assign rd_req_flow  = rd_req_flow_r;
  assign pkt_pending  = pending_s;
  assign busy         = busy_r;
  assign cnt_overflow = cnt_overflow_r;
  assign proto_err    = proto_err_r;

  // Per-flow pending/eligible flags and counter increment/decrement requests.
  always_comb begin
    pending_s  = {N{1'b0}};
    eligible_s = {N{1'b0}};
    inc_s      = {N{1'b0}};
    dec_s      = {N{1'b0}};
    ovf_s      = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      pending_s[i]  = (cnt_r[i] != CNT_ZERO);
      eligible_s[i] = pending_s[i] & flow_enable[i];
      inc_s[i]      = wr_pkt_done & (wr_pkt_flow == FLOWS_W'(i));
      dec_s[i]      = hs_s & (rd_req_flow_r == FLOWS_W'(i));
      // A same-flow decrement cancels the increment, so only a lone increment can overflow.
      ovf_s[i]      = inc_s[i] & ~dec_s[i] & (cnt_r[i] == CNT_MAX);
    end
  end

  // Round-robin search starting just after the last granted flow.
  always_comb begin
    win_s       = {FLOWS_W{1'b0}};
    win_found_s = 1'b0;
    idx_s       = {FLOWS_W{1'b0}};
    for (int k = 1; k <= N; k++) begin
      idx_s = rr_ptr_r + FLOWS_W'(k);
      if (!win_found_s && eligible_s[idx_s]) begin
        win_s       = idx_s;
        win_found_s = 1'b1;
      end else begin
        win_s       = win_s;
      end
    end
  end

  // Pending-packet counters with saturation and sticky overflow flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) cnt_r[i] <= CNT_ZERO;
      cnt_overflow_r <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (inc_s[i] && !dec_s[i]) begin
          if (cnt_r[i] != CNT_MAX) cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end else if (dec_s[i] && !inc_s[i]) begin
          cnt_r[i] <= cnt_r[i] - CNT_ONE;
        end
      end
      cnt_overflow_r <= cnt_overflow_r | (|ovf_s);
    end
  end

  // Grant FSM: IDLE -> REQ (request held) -> ACTIVE (packet in flight).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r        <= ST_IDLE;
      rr_ptr_r       <= {FLOWS_W{1'b1}};
      rd_req_valid_r <= 1'b0;
      rd_req_flow_r  <= {FLOWS_W{1'b0}};
      busy_r         <= 1'b0;
      proto_err_r    <= 1'b0;
    end else begin
      proto_err_r <= proto_err_r | (rd_pkt_done & (state_r != ST_ACTIVE));
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            state_r        <= ST_REQ;
            rd_req_valid_r <= 1'b1;
            rd_req_flow_r  <= win_s;
            busy_r         <= 1'b1;
          end
        end
        ST_REQ: begin
          // The latched flow is never retracted, even if its enable drops here.
          if (rd_req_ready) begin
            state_r        <= ST_ACTIVE;
            rd_req_valid_r <= 1'b0;
            rr_ptr_r       <= rd_req_flow_r;
          end
        end
        ST_ACTIVE: begin
          // Re-arbitrate on the done cycle so the next request has no idle bubble.
          if (rd_pkt_done) begin
            if (win_found_s) begin
              state_r        <= ST_REQ;
              rd_req_valid_r <= 1'b1;
              rd_req_flow_r  <= win_s;
            end else begin
              state_r        <= ST_IDLE;
              busy_r         <= 1'b0;
            end
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          rd_req_valid_r <= 1'b0;
          busy_r         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flow_rd_scheduler.sv
module tb_flow_rd_scheduler;

  localparam int FW   = 3;
  localparam int N    = 8;
  localparam int CW   = 2;
  localparam int MAXC = 3;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         wr_pkt_done = 1'b0;
  logic [FW-1:0] wr_pkt_flow = 3'd0;
  logic [N-1:0] flow_enable = 8'hFF;
  logic         rd_req_valid;
  logic [FW-1:0] rd_req_flow;
  logic         rd_req_ready = 1'b0;
  logic         rd_pkt_done = 1'b0;
  logic [N-1:0] pkt_pending;
  logic         busy;
  logic         cnt_overflow;
  logic         proto_err;

  flow_rd_scheduler #(.FLOWS_W(FW), .PKT_CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn),
    .wr_pkt_done(wr_pkt_done), .wr_pkt_flow(wr_pkt_flow), .flow_enable(flow_enable),
    .rd_req_valid(rd_req_valid), .rd_req_flow(rd_req_flow), .rd_req_ready(rd_req_ready),
    .rd_pkt_done(rd_pkt_done), .pkt_pending(pkt_pending), .busy(busy),
    .cnt_overflow(cnt_overflow), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: packet counts, outstanding request, packet in flight.
  int m_cnt [N];
  int m_last;
  bit m_valid, m_active, m_ovf, m_perr;
  int m_flow;
  int grants[$];
  int exp_rr [6] = '{0, 3, 7, 0, 3, 7};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] en);
    int f;
    for (int k = 1; k <= N; k++) begin
      f = (m_last + k) % N;
      if (m_cnt[f] > 0 && en[f]) return f;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_pending();
    logic [N-1:0] p;
    p = 8'h00;
    for (int i = 0; i < N; i++) p[i] = (m_cnt[i] > 0);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_last = N - 1; m_valid = 1'b0; m_active = 1'b0; m_ovf = 1'b0; m_perr = 1'b0; m_flow = 0;
  endtask

  task automatic model_next(input bit wd, input int wf, input logic [N-1:0] en, input bit rdy, input bit pd);
    int nc [N];
    int w;
    bit hs;
    hs = m_valid && rdy;
    w  = pick(en);
    for (int i = 0; i < N; i++) begin
      nc[i] = m_cnt[i] + ((wd && wf == i) ? 1 : 0) - ((hs && m_flow == i) ? 1 : 0);
      if (nc[i] > MAXC) begin
        nc[i] = MAXC;
        m_ovf = 1'b1;
      end
    end
    if (pd && !m_active) m_perr = 1'b1;
    if (!m_valid && !m_active) begin
      if (w >= 0) begin m_valid = 1'b1; m_flow = w; end
    end else if (m_valid) begin
      if (rdy) begin m_valid = 1'b0; m_active = 1'b1; m_last = m_flow; end
    end else if (pd) begin
      m_active = 1'b0;
      if (w >= 0) begin m_valid = 1'b1; m_flow = w; end
    end
    for (int i = 0; i < N; i++) m_cnt[i] = nc[i];
  endtask

  task automatic check_outputs();
    check_eq("valid", {31'd0, rd_req_valid}, {31'd0, m_valid});
    if (m_valid) check_eq("flow", {29'd0, rd_req_flow}, m_flow);
    check_eq("pending", {24'd0, pkt_pending}, {24'd0, exp_pending()});
    check_eq("busy", {31'd0, busy}, {31'd0, (m_valid | m_active)});
    check_eq("ovf", {31'd0, cnt_overflow}, {31'd0, m_ovf});
    check_eq("perr", {31'd0, proto_err}, {31'd0, m_perr});
  endtask

  // One cycle: check current outputs, drive inputs, advance model, move to next negedge.
  task automatic step(input bit wd, input int wf, input logic [N-1:0] en, input bit rdy, input bit pd);
    check_outputs();
    if (rd_req_valid && rdy) grants.push_back(int'(rd_req_flow));
    wr_pkt_done = wd; wr_pkt_flow = wf[2:0]; flow_enable = en; rd_req_ready = rdy; rd_pkt_done = pd;
    model_next(wd, wf, en, rdy, pd);
    @(negedge clk);
  endtask

  task automatic serve(input int n, input logic [N-1:0] en);
    for (int i = 0; i < n; i++) step(1'b0, 0, en, m_valid, m_active);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    rstn = 1'b0;
    #1;
    check_eq("rst_valid", {31'd0, rd_req_valid}, 32'd0);
    check_eq("rst_flow", {29'd0, rd_req_flow}, 32'd0);
    check_eq("rst_pending", {24'd0, pkt_pending}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ovf", {31'd0, cnt_overflow}, 32'd0);
    check_eq("rst_perr", {31'd0, proto_err}, 32'd0);
    model_reset();
    wr_pkt_done = 1'b0; rd_req_ready = 1'b0; rd_pkt_done = 1'b0; flow_enable = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    logic [N-1:0] en_v;
    bit pd_v;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single flow 5: request two cycles after the write commit.
    step(1'b1, 5, 8'hFF, 1'b0, 1'b0);
    step(1'b0, 0, 8'hFF, 1'b0, 1'b0);
    check_eq("f5_latency_valid", {31'd0, rd_req_valid}, 32'd1);
    check_eq("f5_latency_flow", {29'd0, rd_req_flow}, 32'd5);
    step(1'b0, 0, 8'hFF, 1'b1, 1'b0);
    step(1'b0, 0, 8'hFF, 1'b0, 1'b1);
    check_eq("f5_busy_after", {31'd0, busy}, 32'd0);
    check_eq("f5_pending_after", {24'd0, pkt_pending}, 32'd0);
    // Stray done while idle.
    step(1'b0, 0, 8'hFF, 1'b0, 1'b1);
    check_eq("idle_done_perr", {31'd0, proto_err}, 32'd1);
    check_eq("idle_done_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a packet.
    step(1'b1, 2, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 2, 8'hFF, 1'b0, 1'b0);
    step(1'b0, 0, 8'hFF, 1'b1, 1'b0);
    check_eq("mid_active_busy", {31'd0, busy}, 32'd1);
    do_reset();
    serve(4, 8'hFF);

    // Round-robin over flows 0, 3, 7 with back-to-back completions.
    step(1'b1, 0, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 0, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 3, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 3, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 7, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 7, 8'hFF, 1'b0, 1'b0);
    grants.delete();
    serve(20, 8'hFF);
    check_eq("rr_count", grants.size(), 32'd6);
    for (int i = 0; i < 6 && i < grants.size(); i++) check_eq("rr_order", grants[i], exp_rr[i]);

    // Mask: flow 2 disabled, then re-enabled.
    do_reset();
    step(1'b1, 1, 8'hFB, 1'b0, 1'b0);
    step(1'b1, 2, 8'hFB, 1'b0, 1'b0);
    grants.delete();
    serve(8, 8'hFB);
    check_eq("mask_count", grants.size(), 32'd1);
    check_eq("mask_pending2", {31'd0, pkt_pending[2]}, 32'd1);
    serve(8, 8'hFF);
    check_eq("mask_count2", grants.size(), 32'd2);
    if (grants.size() >= 2) check_eq("mask_second", grants[1], 32'd2);
    // Disabling flow 1 while it is requested still completes the handshake.
    step(1'b1, 1, 8'hFF, 1'b0, 1'b0);
    step(1'b0, 0, 8'hFF, 1'b0, 1'b0);
    step(1'b0, 0, 8'hFD, 1'b1, 1'b0);
    check_eq("mask_req_kept", {31'd0, busy}, 32'd1);
    serve(4, 8'hFD);

    // Same-cycle write commit and handshake on flow 4.
    do_reset();
    step(1'b1, 4, 8'hFF, 1'b0, 1'b0);
    step(1'b0, 0, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 4, 8'hFF, 1'b1, 1'b0);
    check_eq("sim_pending4", {31'd0, pkt_pending[4]}, 32'd1);
    grants.delete();
    serve(8, 8'hFF);
    check_eq("sim_regrant", grants.size(), 32'd1);

    // Saturation on flow 6, then drain it.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 6, 8'hFF, 1'b0, 1'b0);
    check_eq("sat_ovf", {31'd0, cnt_overflow}, 32'd1);
    grants.delete();
    serve(16, 8'hFF);
    check_eq("sat_reads", grants.size(), 32'd3);
    check_eq("sat_drained", {24'd0, pkt_pending}, 32'd0);

    // Randomized traffic against the model, with one reset in the middle.
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      en_v = ($urandom_range(3) == 0) ? 8'($urandom) : 8'hFF;
      pd_v = m_active ? ($urandom_range(2) == 0) : ($urandom_range(40) == 0);
      step($urandom_range(3) == 0, int'($urandom_range(7)), en_v, $urandom_range(1) == 1, pd_v);
      if (c == 1200) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/flow_rd_scheduler.md
# flow_rd_scheduler

Packet-granular round-robin scheduler for the read side of the multichannel segmented buffer. It counts the complete packets committed per flow by the write path. It chooses which flow the read engine drains next, and holds that grant until the read engine reports the packet's last beat delivered. It sits between the write-commit logic and the read engine inside `buffer_top`.

## Interface
Parameters:
- FLOWS_W, 3, flow id width; N = 2**FLOWS_W flows
- PKT_CNT_W, 6, width of each per-flow pending-packet counter

Ports:
- clk  in  1  single clock
- rstn  in  1  reset, asynchronous assert, active-low
- wr_pkt_done  in  1  one-cycle pulse: write path accepted the last beat of a packet
- wr_pkt_flow  in  FLOWS_W  flow of that packet; valid with wr_pkt_done
- flow_enable  in  N  per-flow grant mask; disabled flows still count packets
- rd_req_valid  out  1  request read engine to start one packet
- rd_req_flow  out  FLOWS_W  flow to read; stable while rd_req_valid
- rd_req_ready  in  1  read engine accepts request
- rd_pkt_done  in  1  read engine delivered last beat (s_rvalid & s_rready & s_rlast)
- pkt_pending  out  N  bit i = counter[i] != 0
- busy  out  1  state is REQ or ACTIVE
- cnt_overflow  out  1  sticky: increment attempted on a saturated counter
- proto_err  out  1  sticky: rd_pkt_done outside ACTIVE

## Operation
- Counters: N × PKT_CNT_W.
  - +1 on wr_pkt_done for wr_pkt_flow.
  - −1 on request handshake (rd_req_valid & rd_req_ready) for rd_req_flow.
  - Both in the same cycle on the same flow: no change.
  - Increment at max (2**PKT_CNT_W−1) without a same-flow decrement: counter holds, cnt_overflow set.
- Eligible flow i: counter[i] != 0 and flow_enable[i]. Arbitration uses registered counter values only.
- Round-robin: rr_ptr = last granted flow. Search order rr_ptr+1 … rr_ptr+N, modulo N. The first eligible flow wins. rr_ptr updates on the request handshake.
- FSM:
  - IDLE: if any flow is eligible, latch the winner into rd_req_flow and go to REQ. Otherwise stay.
  - REQ: rd_req_valid=1. On rd_req_ready, decrement the counter, update rr_ptr, go to ACTIVE. The request is never retracted: clearing flow_enable for the latched flow in REQ has no effect on it.
  - ACTIVE: wait for rd_pkt_done. When it arrives, evaluate arbitration the same cycle. Go to REQ with the new winner if any flow is eligible, otherwise to IDLE.
- rd_pkt_done in IDLE or REQ: ignored for state, sets proto_err.
- cnt_overflow and proto_err clear only on reset.

## Timing
- Reset values:
  - rd_req_valid=0, rd_req_flow=0, pkt_pending=0, busy=0, cnt_overflow=0, proto_err=0.
  - All counters 0, rr_ptr=N−1 (flow 0 has first priority), state IDLE.
- pkt_pending and counters update 1 cycle after wr_pkt_done.
- wr_pkt_done at cycle t on an idle scheduler: counter visible at t+1, rd_req_valid=1 at t+2.
- rd_req_ready sampled at t with valid: ACTIVE and decremented counter visible at t+1.
- rd_pkt_done at t with another eligible flow: rd_req_valid=1 at t+1 (no IDLE bubble).
- rd_req_ready is ignored while rd_req_valid=0.
- Asynchronous reset mid-packet: all state is cleared immediately and pending packets are forgotten. The buffer is reset together with the scheduler.

## Test plan
- Single flow: one wr_pkt_done on flow 5 → rd_req_valid with rd_req_flow=5 two cycles later. Assert rd_req_ready then rd_pkt_done → pkt_pending[5]=0, FSM back to IDLE.
- Round-robin: 2 packets each queued on flows 0, 3, 7, all enabled → grant order 0, 3, 7, 0, 3, 7. Back-to-back rd_pkt_done → every next request appears 1 cycle after done.
- Mask: packets on flows 1 and 2, flow_enable=8'b1111_1011 → only flow 1 is granted. Re-enable flow 2 → flow 2 is granted next. Disabling flow 1 during its REQ still completes that handshake.
- Simultaneous events: wr_pkt_done on flow 4 in the same cycle as the handshake for flow 4, counter at 1 → counter stays 1, flow 4 eligible again after done.
- Saturation: PKT_CNT_W=2, 4 pulses on flow 6 with no reads → counter=3, cnt_overflow=1. Three full reads then drain flow 6 to 0.
- Errors and reset: rd_pkt_done while IDLE → proto_err=1, state unchanged. rstn low during ACTIVE → all outputs 0 immediately, no stale request after release.
